// File: rtl/ula_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
interface ula_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       ULAop;
  logic [5:0]       FuncCode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             done;
  logic             busy;
  logic             div_zero;
  logic             illegal;
  logic [4:0]       ULActl;

  modport master (output start, ULAop, FuncCode, a, b,
                  input  result, zero, done, busy, div_zero, illegal, ULActl);
  modport slave  (input  start, ULAop, FuncCode, a, b,
                  output result, zero, done, busy, div_zero, illegal, ULActl);
endinterface

// File: rtl/ula_multiciclo.sv
// ALU-control decoder plus ALU: single-cycle ops finish in one clock,
// MUL/DIV/REM iterate one bit per cycle (shift-add / restoring divide).
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  ula_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [4:0] C_MUL = 5'b00100, C_DIV = 5'b00101, C_REM = 5'b01001;
  localparam logic [4:0] C_ILL = 5'b11111;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc, ma, mb, a_sv;
  logic             is_mul, is_rem, neg_q, neg_r, dz;

  logic [4:0]       ctl;
  logic             is_multi;
  logic [WIDTH-1:0] sc_res, rs, quo, rem, fin_res, abs_a, abs_b;
  logic [WIDTH:0]   trial;

  always_comb begin
    ctl = C_ILL;
    case (bus.ULAop)
      4'b0000: ctl = 5'b00010;
      4'b0001: ctl = 5'b00110;
      4'b0011: ctl = 5'b00000;
      4'b0100: ctl = 5'b00001;
      4'b0101: ctl = 5'b01000;
      4'b0110: ctl = 5'b00111;
      4'b0111: ctl = 5'b01110;
      4'b1000: ctl = 5'b00011;
      4'b0010: begin
        case (bus.FuncCode)
          6'b100000: ctl = 5'b00010;
          6'b100010: ctl = 5'b00110;
          6'b100100: ctl = 5'b00000;
          6'b100101: ctl = 5'b00001;
          6'b100111: ctl = 5'b01100;
          6'b101010: ctl = 5'b00111;
          6'b101001: ctl = 5'b01110;
          6'b101011: ctl = 5'b00011;
          6'b100001: ctl = C_MUL;
          6'b100011: ctl = C_DIV;
          6'b101000: ctl = C_REM;
          6'b101100: ctl = 5'b10000;
          6'b101101: ctl = 5'b01010;
          6'b101110: ctl = 5'b01011;
          6'b101111: ctl = 5'b01101;
          6'b110000: ctl = 5'b01111;
          default:   ctl = C_ILL;
        endcase
      end
      default: ctl = C_ILL;
    endcase
  end

  assign bus.ULActl = ctl;
  assign is_multi   = (ctl == C_MUL) || (ctl == C_DIV) || (ctl == C_REM);
  assign abs_a      = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b      = bus.b[WIDTH-1] ? -bus.b : bus.b;

  always_comb begin
    sc_res = '0;
    case (ctl)
      5'b00010: sc_res = bus.a + bus.b;
      5'b00110: sc_res = bus.a - bus.b;
      5'b00000: sc_res = bus.a & bus.b;
      5'b00001: sc_res = bus.a | bus.b;
      5'b01100: sc_res = ~bus.a;
      5'b01000: sc_res = bus.b << (WIDTH/2);
      5'b01110: sc_res = bus.a << bus.b[SHW-1:0];
      5'b00011: sc_res = bus.a >> bus.b[SHW-1:0];
      5'b00111: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <  $signed(bus.b)};
      5'b10000: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) <= $signed(bus.b)};
      5'b01010: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) >  $signed(bus.b)};
      5'b01011: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) >= $signed(bus.b)};
      5'b01101: sc_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      5'b01111: sc_res = {{(WIDTH-1){1'b0}}, bus.a != bus.b};
      default:  sc_res = '0;
    endcase
  end

  // Restoring divide: {acc,ma} shifts left, ma collects quotient bits.
  // The partial remainder stays below |b| <= 2^(WIDTH-1), so dropping acc's MSB is safe.
  assign rs    = {acc[WIDTH-2:0], ma[WIDTH-1]};
  assign trial = {1'b0, rs} - {1'b0, mb};

  always_comb begin
    quo = neg_q ? -ma  : ma;
    rem = neg_r ? -acc : acc;
    if (dz) begin
      quo = '1;
      rem = a_sv;
    end
    fin_res = is_mul ? acc : (is_rem ? rem : quo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      ma           <= '0;
      mb           <= '0;
      a_sv         <= '0;
      is_mul       <= 1'b0;
      is_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b1;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (is_multi) begin
            is_mul   <= (ctl == C_MUL);
            is_rem   <= (ctl == C_REM);
            // Low product bits do not depend on signedness, so mul uses raw operands.
            ma       <= (ctl == C_MUL) ? bus.a : abs_a;
            mb       <= (ctl == C_MUL) ? bus.b : abs_b;
            acc      <= '0;
            a_sv     <= bus.a;
            neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r    <= bus.a[WIDTH-1];
            dz       <= (ctl != C_MUL) && (bus.b == '0);
            cnt      <= SHW'(WIDTH-1);
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            bus.result   <= sc_res;
            bus.zero     <= (sc_res == '0);
            bus.div_zero <= 1'b0;
            bus.illegal  <= (ctl == C_ILL);
            bus.done     <= 1'b1;
          end
        end
        CALC: begin
          if (is_mul) begin
            if (mb[0]) acc <= acc + ma;
            ma <= ma << 1;
            mb <= mb >> 1;
          end else begin
            acc <= trial[WIDTH] ? rs : trial[WIDTH-1:0];
            ma  <= {ma[WIDTH-2:0], ~trial[WIDTH]};
          end
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - 1'b1;
        end
        FIN: begin
          bus.result   <= fin_res;
          bus.zero     <= (fin_res == '0);
          bus.div_zero <= dz;
          bus.illegal  <= 1'b0;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomised scoreboard bench for ula_multiciclo against an arithmetic reference model.
module tb_ula_multiciclo;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    logic         ill;
    int           cyc;
    int           id;
  } exp_t;

  localparam logic [5:0] FCS [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h29, 6'h2B,
                                      6'h21, 6'h23, 6'h28, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h30};
  localparam logic [3:0] OPS [8]  = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   next_id = 0;
  exp_t sb[$];

  ula_if #(.WIDTH(W)) bus();
  ula_multiciclo #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: decode table, then plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [5:0] fc,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [4:0] ctl, output bit multi,
                                output logic [W-1:0] res, output logic dz);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    multi = 0;
    case (op)
      4'd0: ctl = 5'b00010;  4'd1: ctl = 5'b00110;  4'd3: ctl = 5'b00000;
      4'd4: ctl = 5'b00001;  4'd5: ctl = 5'b01000;  4'd6: ctl = 5'b00111;
      4'd7: ctl = 5'b01110;  4'd8: ctl = 5'b00011;
      4'd2: case (fc)
        6'h20: ctl = 5'b00010;  6'h22: ctl = 5'b00110;  6'h24: ctl = 5'b00000;
        6'h25: ctl = 5'b00001;  6'h27: ctl = 5'b01100;  6'h2A: ctl = 5'b00111;
        6'h29: ctl = 5'b01110;  6'h2B: ctl = 5'b00011;  6'h21: ctl = 5'b00100;
        6'h23: ctl = 5'b00101;  6'h28: ctl = 5'b01001;  6'h2C: ctl = 5'b10000;
        6'h2D: ctl = 5'b01010;  6'h2E: ctl = 5'b01011;  6'h2F: ctl = 5'b01101;
        6'h30: ctl = 5'b01111;
        default: ctl = 5'b11111;
      endcase
      default: ctl = 5'b11111;
    endcase
    case (ctl)
      5'b00010: res = W'(sa + sb);
      5'b00110: res = W'(sa - sb);
      5'b00000: res = a & b;
      5'b00001: res = a | b;
      5'b01100: res = ~a;
      5'b01000: res = W'(longint'(b) * 65536);
      5'b01110: res = W'(longint'(a) * (longint'(1) << b[4:0]));
      5'b00011: res = W'(longint'(a) / (longint'(1) << b[4:0]));
      5'b00111: res = W'(sa <  sb);
      5'b10000: res = W'(sa <= sb);
      5'b01010: res = W'(sa >  sb);
      5'b01011: res = W'(sa >= sb);
      5'b01101: res = W'(sa == sb);
      5'b01111: res = W'(sa != sb);
      5'b00100: begin multi = 1; res = W'(sa * sb); end
      5'b00101: begin multi = 1; dz = (b == 0); res = dz ? {W{1'b1}} : W'(sa / sb); end
      5'b01001: begin multi = 1; dz = (b == 0); res = dz ? a : W'(sa % sb); end
      default:  res = '0;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge (for multi-cycle ops, the one where done is high).
  task automatic send(input logic [3:0] op, input logic [5:0] fc,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit inj);
    exp_t e;
    logic [4:0] ctl;
    bit multi, got;
    int nb;
    model(op, fc, a, b, ctl, multi, e.res, e.dz);
    e.ill = (ctl == 5'b11111);
    e.id  = next_id++;
    e.cyc = cyc + 1 + (multi ? W + 1 : 0);
    bus.ULAop = op; bus.FuncCode = fc; bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back(e);
    #1 chk($sformatf("ULActl op=%h fc=%h", op, fc), W'(bus.ULActl), W'(ctl));
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (!multi) begin
      @(negedge clk);
    end else begin
      got = 0; nb = 0;
      for (int i = 0; i < W + 10; i++) begin
        @(negedge clk);
        if (bus.done) begin got = 1; break; end
        if (bus.busy) nb++;
        if (inj && i == 4) begin
          bus.ULAop = 4'd0; bus.a = 1; bus.b = 1; bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
      end
      chk($sformatf("done seen id=%0d", e.id), W'(got), W'(1));
      chk($sformatf("busy cycles id=%0d", e.id), W'(nb), W'(W + 1));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", W'(bus.done), W'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result id=%0d", e.id),   bus.result, e.res);
        chk($sformatf("zero id=%0d", e.id),     W'(bus.zero), W'(e.res == 0));
        chk($sformatf("div_zero id=%0d", e.id), W'(bus.div_zero), W'(e.dz));
        chk($sformatf("illegal id=%0d", e.id),  W'(bus.illegal), W'(e.ill));
        chk($sformatf("latency id=%0d", e.id),  W'(cyc), W'(e.cyc));
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.ULAop = '0; bus.FuncCode = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset result", bus.result, '0);
    chk("reset zero", W'(bus.zero), W'(1));
    chk("reset done", W'(bus.done), W'(0));
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset div_zero", W'(bus.div_zero), W'(0));
    chk("reset illegal", W'(bus.illegal), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    send(4'd0, 6'h00, 7, 5, 0);
    send(4'd1, 6'h00, 5, 5, 0);
    send(4'd2, 6'h2C, -3, -3, 0);
    send(4'd2, 6'h2D, -1, 1, 0);
    send(4'd2, 6'h21, -6, 7, 1);
    send(4'd2, 6'h23, -17, 5, 0);
    send(4'd2, 6'h28, -17, 5, 0);
    send(4'd2, 6'h23, 9, 0, 0);
    send(4'd2, 6'h28, -9, 0, 0);
    send(4'd2, 6'h23, 32'h8000_0000, -1, 0);
    send(4'd2, 6'h28, 32'h8000_0000, -1, 0);
    send(4'd2, 6'h29, 1, 35, 0);
    send(4'd5, 6'h00, 0, 32'h1234, 0);
    send(4'd2, 6'h3F, 3, 4, 0);
    send(4'd12, 6'h20, 3, 4, 0);

    // Abort a divide mid-CALC; no done may follow.
    bus.ULAop = 4'd2; bus.FuncCode = 6'h23; bus.a = 100; bus.b = 7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy", W'(bus.busy), W'(0));
    chk("abort done", W'(bus.done), W'(0));
    chk("abort result", bus.result, '0);
    chk("abort zero", W'(bus.zero), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd0, 6'h00, 40, 2, 0);

    for (int n = 0; n < 80; n++) begin
      int r;
      logic [3:0] op;
      logic [5:0] fc;
      r  = $urandom_range(0, 19);
      fc = FCS[$urandom_range(0, 15)];
      if (r < 12)      op = 4'd2;
      else if (r < 19) op = OPS[$urandom_range(0, 7)];
      else begin
        op = 4'd2;
        fc = 6'($urandom);
      end
      if (r == 18) op = 4'($urandom_range(9, 15));
      send(op, fc, pick(), pick(), 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
